rr_arb16: RTL

Registered 16-requester round-robin arbiter that shares one datapath resource (e.g. a PE row write port or a memory bank) between up to 16 clients. It issues one-hot and encoded grants, holds each grant until the owner releases, abandons or times out, and rotates priority so that every requester is served. At reset, priority ordering is lowest-index-first, the same ordering the 16-to-4 encoders use elsewhere in the design.

---
 rtl/rr_arb16.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rr_arb16.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb16
// Description : Registered 16-requester round-robin arbiter with hold-until-
//               release grants, abandon detection and an optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb16 #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        rel,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_vld,
    output logic        to_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last cycle index of a grant; only meaningful when TIMEOUT is non-zero.
    localparam logic [7:0] c_TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         c_TO_EN   = (TIMEOUT != 0);

    state_t      r_state;
    logic [3:0]  r_ptr;
    logic [7:0]  r_cnt;
    logic [15:0] r_gnt;
    logic [3:0]  r_gnt_id;
    logic        r_gnt_vld;
    logic        r_to_err;

    state_t      w_state_nxt;
    logic [3:0]  w_ptr_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] w_gnt_nxt;
    logic [3:0]  w_gnt_id_nxt;
    logic        w_gnt_vld_nxt;
    logic        w_to_err_nxt;

    logic        w_owner_req;
    logic        w_to_hit;
    logic        w_end;
    logic [15:0] w_sel_req;
    logic [3:0]  w_base;
    logic [3:0]  w_idx;
    logic [3:0]  w_win;
    logic        w_any;

    // End-of-grant conditions for the current owner.
    always_comb begin
        w_owner_req = req[r_gnt_id];
        w_to_hit    = c_TO_EN && (r_cnt == c_TO_LAST);
        w_end       = rel || !w_owner_req || w_to_hit;
    end

    // Candidate set and search start. During a grant the search always begins
    // just after the owner, which is exactly the pointer value being written.
    // An owner that did not release voluntarily is kept out of the re-run.
    always_comb begin
        w_sel_req = req;
        w_base    = r_ptr;
        if (r_state == GRANT) begin
            w_base = r_gnt_id + 4'd1;
            if (!rel) begin
                w_sel_req = req & ~r_gnt;
            end
        end
    end

    // Rotating priority search: first set bit at or after w_base, mod 16.
    always_comb begin
        w_any = 1'b0;
        w_win = 4'd0;
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_idx = w_base + 4'(i);
            if (!w_any && w_sel_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_vld_nxt = r_gnt_vld;
        w_to_err_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = GRANT;
                    w_gnt_nxt     = 16'h0001 << w_win;
                    w_gnt_id_nxt  = w_win;
                    w_gnt_vld_nxt = 1'b1;
                    w_cnt_nxt     = 8'd0;
                end
            end

            GRANT: begin
                if (w_end) begin
                    w_ptr_nxt    = r_gnt_id + 4'd1;
                    // Only a forced end with the owner still requesting is an error.
                    w_to_err_nxt = !rel && w_owner_req;
                    w_cnt_nxt    = 8'd0;
                    if (w_any) begin
                        w_gnt_nxt     = 16'h0001 << w_win;
                        w_gnt_id_nxt  = w_win;
                        w_gnt_vld_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_gnt_nxt     = 16'h0000;
                        w_gnt_id_nxt  = 4'd0;
                        w_gnt_vld_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_gnt_nxt     = 16'h0000;
                w_gnt_id_nxt  = 4'd0;
                w_gnt_vld_nxt = 1'b0;
                w_cnt_nxt     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 4'd0;
            r_cnt     <= 8'd0;
            r_gnt     <= 16'h0000;
            r_gnt_id  <= 4'd0;
            r_gnt_vld <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_to_err  <= w_to_err_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign to_err  = r_to_err;

endmodule
`default_nettype wire
